// File: rtl/vector_dot_product_seq.sv
// Operand sequencer for the dot-product engine: gathers element pairs into
// two vectors, starts the engine, and returns its result or a timeout error.
module vector_dot_product_seq #(
  parameter int VECTOR_SIZE    = 4,
  parameter int DATA_WIDTH     = 31,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [DATA_WIDTH-1:0] vec1 [VECTOR_SIZE],
  output logic [DATA_WIDTH-1:0] vec2 [VECTOR_SIZE],
  output logic                  dp_start,
  input  logic                  dp_valid,
  input  logic [DATA_WIDTH-1:0] dp_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err,
  output logic                  busy
);

  localparam int IW = $clog2(VECTOR_SIZE);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_SIZE - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_OUT
  } state_e;

  state_e                state_q;
  logic [IW-1:0]         idx_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] vec1_q [VECTOR_SIZE];
  logic [DATA_WIDTH-1:0] vec2_q [VECTOR_SIZE];
  logic [DATA_WIDTH-1:0] res_data_q;
  logic                  res_err_q;
  logic                  res_valid_q;
  logic                  dp_start_q;
  logic                  beat_d;

  assign in_ready  = reset && (state_q == S_LOAD);
  assign busy      = (state_q == S_START) || (state_q == S_WAIT);
  assign beat_d    = in_valid && in_ready;
  assign vec1      = vec1_q;
  assign vec2      = vec2_q;
  assign dp_start  = dp_start_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      dp_start_q  <= 1'b0;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        vec1_q[i] <= '0;
        vec2_q[i] <= '0;
      end
    end else begin
      dp_start_q <= 1'b0;
      unique case (state_q)
        S_LOAD: begin
          if (beat_d) begin
            vec1_q[idx_q] <= in_a;
            vec2_q[idx_q] <= in_b;
            if (idx_q == LAST_IDX) begin
              idx_q      <= '0;
              state_q    <= S_START;
              dp_start_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // an engine answer wins over a timeout landing in the same cycle
          if (dp_valid) begin
            res_data_q  <= dp_result;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else if (cnt_q == CNT_MAX) begin
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule

// File: doc/vector_dot_product_seq.md
# vector_dot_product_seq

Front-end sequencer for the multi-cycle vector dot-product engine. Accepts operand pairs one element per beat over a valid/ready stream and assembles them into two parallel vectors. Holds those vectors stable for the engine and issues a start pulse, then captures the engine's result and returns it over an output valid/ready stream with a timeout error flag. It is the producer and consumer end of the engine's `vec1`/`vec2`/`result`/`valid` interface.

## Interface
- `VECTOR_SIZE`, 4: elements per vector; must be ≥ 2.
- `DATA_WIDTH`, 31: width of every element and of the result.
- `TIMEOUT_CYCLES`, 64: maximum number of WAIT cycles before the sequencer aborts; must be ≥ 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  operand beat accepted when `in_valid && in_ready`.
- `in_a`  in  DATA_WIDTH  element for `vec1`.
- `in_b`  in  DATA_WIDTH  element for `vec2`.
- `vec1`  out  VECTOR_SIZE × DATA_WIDTH  operand vector 1 to the engine (unpacked array, index 0 first).
- `vec2`  out  VECTOR_SIZE × DATA_WIDTH  operand vector 2 to the engine.
- `dp_start`  out  1  one-cycle start pulse to the engine.
- `dp_valid`  in  1  engine result valid.
- `dp_result`  in  DATA_WIDTH  engine result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result when `res_valid && res_ready`.
- `res_data`  out  DATA_WIDTH  captured result.
- `res_err`  out  1  timeout flag; qualified by `res_valid`.
- `busy`  out  1  high in START and WAIT.

## Operation
- States: LOAD, START, WAIT, OUTPUT. Reset state is LOAD.
- Reset (`reset`=0 at an edge) sets:
  - state=LOAD, element index=0, timeout counter=0;
  - every `vec1`/`vec2` element=0;
  - `res_data`=0, `res_err`=0, `res_valid`=0, `dp_start`=0, `busy`=0.
- `in_ready`=0 while `reset` is low.
- LOAD:
  - `in_ready`=1.
  - Each handshake writes `in_a` to `vec1[idx]` and `in_b` to `vec2[idx]`, then idx++.
  - The handshake with idx=VECTOR_SIZE-1 sets idx=0 and moves to START.
  - Cycles with `in_valid`=0 change nothing.
- START:
  - `dp_start`=1 for exactly this cycle; `in_ready`=0.
  - Moves to WAIT unconditionally; timeout counter is cleared to 0.
- WAIT:
  - If `dp_valid`=1: capture `dp_result` into `res_data`, set `res_err`=0, go to OUTPUT.
  - Otherwise, if counter==TIMEOUT_CYCLES-1: set `res_data`=0, `res_err`=1, go to OUTPUT.
  - Otherwise counter++.
  - `dp_valid` takes priority over timeout when both occur in the same cycle.
- OUTPUT:
  - `res_valid`=1; `res_data` and `res_err` are stable until the handshake.
  - On `res_ready`=1, go to LOAD.
- `dp_valid` is ignored in LOAD, START and OUTPUT.
- `vec1`/`vec2` change only on LOAD handshakes, so they are stable from START through OUTPUT. They keep their last values across blocks; they are not cleared between blocks.
- The result is passed through unmodified. Width and truncation are the engine's responsibility.

## Timing
- Last input handshake at edge N: `dp_start`=1 during cycle N+1, WAIT from cycle N+2.
- `dp_valid` high in WAIT at edge M: `res_valid`=1 from cycle M+1.
- Result handshake at edge K: `in_ready`=1 in cycle K+1. No new beats are accepted in START/WAIT/OUTPUT.
- Minimum block period: VECTOR_SIZE + 1 (START) + 1 (WAIT) + 1 (OUTPUT) cycles, with zero engine latency and `res_ready` tied high.
- Timeout asserts `res_valid` exactly TIMEOUT_CYCLES+1 cycles after the START cycle.
- Reset mid-block (any state) aborts immediately:
  - no `dp_start` is issued afterwards for the aborted block;
  - partially loaded elements are discarded; the vectors are zeroed.
- Outputs are registered except `in_ready` and `busy`, which decode the state register.

## Test plan
- Load (1,5),(2,6),(3,7),(4,8) with an engine model answering 70 three cycles after `dp_start`. Required: `vec1`={1,2,3,4}, `vec2`={5,6,7,8}, one `dp_start` pulse one cycle after the 4th beat, `res_data`=70, `res_err`=0.
- Same vectors with `in_valid` toggled 1/0 every cycle. Required: 4 handshakes only, correct vector contents, `dp_start` after the 4th accepted beat.
- `res_ready` held low 5 cycles after `res_valid`. Required: `res_valid`=1, `res_data`=70 stable, `in_ready`=0 throughout; LOAD the cycle after `res_ready`=1.
- Engine never asserts `dp_valid`. Required: `res_valid` rises 65 cycles after the START cycle with `res_data`=0, `res_err`=1.
- Spurious `dp_valid`=1 during LOAD and in the same cycle as the timeout. Required: ignored in LOAD; in the timeout cycle `dp_result` is captured with `res_err`=0.
- `reset`=0 for one cycle during WAIT. Required: all outputs return to reset values, state LOAD, no `res_valid`; the next 4-beat block completes normally.
